regfile_bypass: RTL and testbench

Parametrised integer register file for the NPC core: the next generation of the single-write, dual-read file. It has a configurable width and depth, two independent write-back ports, registered read ports with same-cycle write bypass, and a per-register busy scoreboard. It sits between decode (read and issue) and the ALU/LSU write-back stages, and gives decode both operands and hazard status.

---
 rtl/regfile_bypass_if.sv | 48 ++++
 rtl/regfile_bypass.sv | 88 ++++++++
 tb/tb_regfile_bypass.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_bypass_if.sv
// Purpose : bundles the write-back, read and issue signals of the integer register file.
// Latency : pure wiring; no storage in the interface.
// Backpr. : none; every transfer is accepted in the cycle it is presented.
// Modports: master = decode / write-back side (drives requests, receives data and busy),
//           slave  = register file (receives requests, drives data and busy).
interface regfile_bypass_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    // write-back port 0 (ALU) and port 1 (LSU)
    logic            wb0_en_i;
    logic [AW-1:0]   wb0_addr_i;
    logic [XLEN-1:0] wb0_data_i;
    logic            wb1_en_i;
    logic [AW-1:0]   wb1_addr_i;
    logic [XLEN-1:0] wb1_data_i;

    // operand reads
    logic            rd_en_i;
    logic [AW-1:0]   rs1_addr_i;
    logic [AW-1:0]   rs2_addr_i;
    logic [XLEN-1:0] rs1_data_o;
    logic [XLEN-1:0] rs2_data_o;
    logic            rs1_busy_o;
    logic            rs2_busy_o;

    // producer issue
    logic            issue_en_i;
    logic [AW-1:0]   issue_rd_i;

    modport master (
        output wb0_en_i, wb0_addr_i, wb0_data_i,
        output wb1_en_i, wb1_addr_i, wb1_data_i,
        output rd_en_i, rs1_addr_i, rs2_addr_i,
        output issue_en_i, issue_rd_i,
        input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o
    );

    modport slave (
        input  wb0_en_i, wb0_addr_i, wb0_data_i,
        input  wb1_en_i, wb1_addr_i, wb1_data_i,
        input  rd_en_i, rs1_addr_i, rs2_addr_i,
        input  issue_en_i, issue_rd_i,
        output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o
    );
endinterface

// File: rtl/regfile_bypass.sv
// Purpose : dual write-back, dual read register file with write-first bypass and busy scoreboard.
// Latency : reads 1 cycle (registered); busy outputs combinational, issue visible next cycle.
// Backpr. : none; writes, reads and issues are always accepted.
// Ports   : clk, rst_n (synchronous, active-low); rf = regfile_bypass_if.slave carrying
//           wb0/wb1 write-back, rd_en/rs1/rs2 reads with data+busy, issue_en/issue_rd.
module regfile_bypass #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input logic             clk,
    input logic             rst_n,
    regfile_bypass_if.slave rf
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic [XLEN-1:0] rs1_nxt, rs2_nxt;

    // Writes to x0 are dropped here, so x0 never matches a bypass or clears busy.
    logic wb0_hit, wb1_hit;
    assign wb0_hit = rf.wb0_en_i && (rf.wb0_addr_i != '0);
    assign wb1_hit = rf.wb1_en_i && (rf.wb1_addr_i != '0);

    // Write-first read mux: port 1 ahead of port 0, x0 forced to zero.
    always_comb begin
        rs1_nxt = mem[rf.rs1_addr_i];
        if (rf.rs1_addr_i == '0)
            rs1_nxt = '0;
        else if (wb1_hit && rf.wb1_addr_i == rf.rs1_addr_i)
            rs1_nxt = rf.wb1_data_i;
        else if (wb0_hit && rf.wb0_addr_i == rf.rs1_addr_i)
            rs1_nxt = rf.wb0_data_i;
    end

    always_comb begin
        rs2_nxt = mem[rf.rs2_addr_i];
        if (rf.rs2_addr_i == '0)
            rs2_nxt = '0;
        else if (wb1_hit && rf.wb1_addr_i == rf.rs2_addr_i)
            rs2_nxt = rf.wb1_data_i;
        else if (wb0_hit && rf.wb0_addr_i == rf.rs2_addr_i)
            rs2_nxt = rf.wb0_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                mem[i] <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            busy  <= '0;
        end else begin
            // Port 1 assigned last so it wins a same-address collision.
            if (wb0_hit)
                mem[rf.wb0_addr_i] <= rf.wb0_data_i;
            if (wb1_hit)
                mem[rf.wb1_addr_i] <= rf.wb1_data_i;

            if (rf.rd_en_i) begin
                rs1_q <= rs1_nxt;
                rs2_q <= rs2_nxt;
            end

            // Entry 0 is never touched so it stays not-busy. A same-cycle issue
            // beats the clear because the issued instruction is the newer producer.
            for (int i = 1; i < NREG; i++) begin
                if (rf.issue_en_i && rf.issue_rd_i == AW'(i))
                    busy[i] <= 1'b1;
                else if ((wb0_hit && rf.wb0_addr_i == AW'(i)) ||
                         (wb1_hit && rf.wb1_addr_i == AW'(i)))
                    busy[i] <= 1'b0;
            end
        end
    end

    assign rf.rs1_data_o = rs1_q;
    assign rf.rs2_data_o = rs2_q;

    // An operand being written back this cycle is bypassed, so it is not a hazard.
    assign rf.rs1_busy_o = busy[rf.rs1_addr_i]
                         && !(wb0_hit && rf.wb0_addr_i == rf.rs1_addr_i)
                         && !(wb1_hit && rf.wb1_addr_i == rf.rs1_addr_i);
    assign rf.rs2_busy_o = busy[rf.rs2_addr_i]
                         && !(wb0_hit && rf.wb0_addr_i == rf.rs2_addr_i)
                         && !(wb1_hit && rf.wb1_addr_i == rf.rs2_addr_i);
endmodule

// File: tb/tb_regfile_bypass.sv
// Purpose : directed checks of regfile_bypass at three parameter sets driven in lockstep.
// Latency : compares registered data one cycle after the read, busy combinationally.
// Backpr. : not applicable; stimulus is free-running.
module tb_regfile_bypass;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Shared stimulus; addresses stay below 16 and data below 2^32 so every
    // configuration must produce identical results.
    logic        wb0_en, wb1_en, rd_en, issue_en;
    logic [5:0]  wb0_addr, wb1_addr, rs1_addr, rs2_addr, issue_rd;
    logic [63:0] wb0_data, wb1_data;

    regfile_bypass_if #(.XLEN(64), .NREG(32)) if_a ();
    regfile_bypass_if #(.XLEN(32), .NREG(16)) if_b ();
    regfile_bypass_if #(.XLEN(64), .NREG(64)) if_c ();

    assign if_a.wb0_en_i = wb0_en;   assign if_b.wb0_en_i = wb0_en;   assign if_c.wb0_en_i = wb0_en;
    assign if_a.wb1_en_i = wb1_en;   assign if_b.wb1_en_i = wb1_en;   assign if_c.wb1_en_i = wb1_en;
    assign if_a.rd_en_i = rd_en;     assign if_b.rd_en_i = rd_en;     assign if_c.rd_en_i = rd_en;
    assign if_a.issue_en_i = issue_en; assign if_b.issue_en_i = issue_en; assign if_c.issue_en_i = issue_en;
    assign if_a.wb0_addr_i = wb0_addr[4:0]; assign if_b.wb0_addr_i = wb0_addr[3:0]; assign if_c.wb0_addr_i = wb0_addr;
    assign if_a.wb1_addr_i = wb1_addr[4:0]; assign if_b.wb1_addr_i = wb1_addr[3:0]; assign if_c.wb1_addr_i = wb1_addr;
    assign if_a.rs1_addr_i = rs1_addr[4:0]; assign if_b.rs1_addr_i = rs1_addr[3:0]; assign if_c.rs1_addr_i = rs1_addr;
    assign if_a.rs2_addr_i = rs2_addr[4:0]; assign if_b.rs2_addr_i = rs2_addr[3:0]; assign if_c.rs2_addr_i = rs2_addr;
    assign if_a.issue_rd_i = issue_rd[4:0]; assign if_b.issue_rd_i = issue_rd[3:0]; assign if_c.issue_rd_i = issue_rd;
    assign if_a.wb0_data_i = wb0_data; assign if_b.wb0_data_i = wb0_data[31:0]; assign if_c.wb0_data_i = wb0_data;
    assign if_a.wb1_data_i = wb1_data; assign if_b.wb1_data_i = wb1_data[31:0]; assign if_c.wb1_data_i = wb1_data;

    regfile_bypass #(.XLEN(64), .NREG(32)) dut_a (.clk(clk), .rst_n(rst_n), .rf(if_a));
    regfile_bypass #(.XLEN(32), .NREG(16)) dut_b (.clk(clk), .rst_n(rst_n), .rf(if_b));
    regfile_bypass #(.XLEN(64), .NREG(64)) dut_c (.clk(clk), .rst_n(rst_n), .rf(if_c));

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [63:0] d1, input logic [63:0] d2);
        chk({"A ", tag, " rs1_data"}, if_a.rs1_data_o, d1);
        chk({"A ", tag, " rs2_data"}, if_a.rs2_data_o, d2);
        chk({"B ", tag, " rs1_data"}, {32'b0, if_b.rs1_data_o}, d1);
        chk({"B ", tag, " rs2_data"}, {32'b0, if_b.rs2_data_o}, d2);
        chk({"C ", tag, " rs1_data"}, if_c.rs1_data_o, d1);
        chk({"C ", tag, " rs2_data"}, if_c.rs2_data_o, d2);
    endtask

    task automatic chk_busy(input string tag, input logic b1, input logic b2);
        chk({"A ", tag, " rs1_busy"}, {63'b0, if_a.rs1_busy_o}, {63'b0, b1});
        chk({"A ", tag, " rs2_busy"}, {63'b0, if_a.rs2_busy_o}, {63'b0, b2});
        chk({"B ", tag, " rs1_busy"}, {63'b0, if_b.rs1_busy_o}, {63'b0, b1});
        chk({"B ", tag, " rs2_busy"}, {63'b0, if_b.rs2_busy_o}, {63'b0, b2});
        chk({"C ", tag, " rs1_busy"}, {63'b0, if_c.rs1_busy_o}, {63'b0, b1});
        chk({"C ", tag, " rs2_busy"}, {63'b0, if_c.rs2_busy_o}, {63'b0, b2});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb0_en = 1'b0; wb0_addr = '0; wb0_data = '0;
        wb1_en = 1'b0; wb1_addr = '0; wb1_data = '0;
        rd_en = 1'b0; rs1_addr = '0; rs2_addr = '0;
        issue_en = 1'b0; issue_rd = '0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        rs1_addr = 6'd5; rs2_addr = 6'd9;
        #1;
        chk_data("reset", 64'h0, 64'h0);
        chk_busy("reset", 1'b0, 1'b0);

        // Reset mid-operation: reset must beat a write, an issue and a read.
        wb0_en = 1'b1; wb0_addr = 6'd5; wb0_data = 64'hDEAD;
        step();
        rst_n = 1'b0; rd_en = 1'b1; rs1_addr = 6'd5; rs2_addr = 6'd5;
        issue_en = 1'b1; issue_rd = 6'd5;
        step();
        rst_n = 1'b1; idle();
        rd_en = 1'b1; rs1_addr = 6'd5; rs2_addr = 6'd5;
        #1;
        chk_data("mid_reset", 64'h0, 64'h0);
        chk_busy("mid_reset", 1'b0, 1'b0);
        step();
        chk_data("x5_after_reset", 64'h0, 64'h0);

        // Basic write / read and x0.
        idle();
        wb0_en = 1'b1; wb0_addr = 6'd3; wb0_data = 64'h1234;
        step();
        idle();
        rd_en = 1'b1; rs1_addr = 6'd3; rs2_addr = 6'd0;
        wb0_en = 1'b1; wb0_addr = 6'd0; wb0_data = 64'hFFFF;
        step();
        chk_data("x3_x0_bypass", 64'h1234, 64'h0);
        idle();
        rd_en = 1'b1; rs1_addr = 6'd0; rs2_addr = 6'd3;
        step();
        chk_data("x0_x3", 64'h0, 64'h1234);

        // Bypass with port 1 winning over port 0.
        idle();
        wb0_en = 1'b1; wb0_addr = 6'd7; wb0_data = 64'hAAAA;
        wb1_en = 1'b1; wb1_addr = 6'd7; wb1_data = 64'hBBBB;
        rd_en = 1'b1; rs1_addr = 6'd7; rs2_addr = 6'd7;
        step();
        chk_data("x7_priority_bypass", 64'hBBBB, 64'hBBBB);
        idle();
        rd_en = 1'b1; rs1_addr = 6'd7; rs2_addr = 6'd3;
        step();
        chk_data("x7_stored", 64'hBBBB, 64'h1234);

        // Port 0 bypass alone.
        idle();
        wb0_en = 1'b1; wb0_addr = 6'd4; wb0_data = 64'h0BAD_F00D;
        rd_en = 1'b1; rs1_addr = 6'd3; rs2_addr = 6'd4;
        step();
        chk_data("x4_port0_bypass", 64'h1234, 64'h0BAD_F00D);

        // Read hold while rd_en is low, even across a write to the held register.
        idle();
        rd_en = 1'b1; rs1_addr = 6'd3; rs2_addr = 6'd7;
        step();
        chk_data("hold_load", 64'h1234, 64'hBBBB);
        idle();
        rs1_addr = 6'd1; rs2_addr = 6'd2;
        wb0_en = 1'b1; wb0_addr = 6'd3; wb0_data = 64'h5555;
        step();
        chk_data("hold_1", 64'h1234, 64'hBBBB);
        idle();
        rs1_addr = 6'd4; rs2_addr = 6'd5;
        step();
        chk_data("hold_2", 64'h1234, 64'hBBBB);
        idle();
        rd_en = 1'b1; rs1_addr = 6'd3; rs2_addr = 6'd7;
        step();
        chk_data("hold_release", 64'h5555, 64'hBBBB);

        // Scoreboard: issue, then combinational clear on write-back.
        idle();
        issue_en = 1'b1; issue_rd = 6'd9;
        rs1_addr = 6'd9; rs2_addr = 6'd0;
        #1;
        chk_busy("issue_same_cycle", 1'b0, 1'b0);
        step();
        idle();
        rs1_addr = 6'd9; rs2_addr = 6'd3;
        #1;
        chk_busy("x9_busy", 1'b1, 1'b0);
        wb1_en = 1'b1; wb1_addr = 6'd9; wb1_data = 64'h9999;
        rd_en = 1'b1; rs1_addr = 6'd9; rs2_addr = 6'd9;
        #1;
        chk_busy("x9_wb_clear", 1'b0, 1'b0);
        step();
        chk_data("x9_wb_bypass", 64'h9999, 64'h9999);
        idle();
        rs1_addr = 6'd9; rs2_addr = 6'd9;
        #1;
        chk_busy("x9_cleared", 1'b0, 1'b0);

        // Issue and write-back to the same register in one cycle: stays busy.
        issue_en = 1'b1; issue_rd = 6'd9;
        wb0_en = 1'b1; wb0_addr = 6'd9; wb0_data = 64'h4242;
        rd_en = 1'b1;
        step();
        chk_data("x9_issue_wb_data", 64'h4242, 64'h4242);
        idle();
        rs1_addr = 6'd9; rs2_addr = 6'd3;
        #1;
        chk_busy("x9_issue_wins", 1'b1, 1'b0);

        // Duplicate issue keeps it busy; issue of a second register on rs2.
        issue_en = 1'b1; issue_rd = 6'd9;
        step();
        idle();
        issue_en = 1'b1; issue_rd = 6'd12;
        rs1_addr = 6'd9; rs2_addr = 6'd12;
        #1;
        chk_busy("dup_issue", 1'b1, 1'b0);
        step();
        idle();
        rs1_addr = 6'd9; rs2_addr = 6'd12;
        #1;
        chk_busy("x12_busy", 1'b1, 1'b1);

        // Issue to x0 never sets busy; x0 reads zero.
        idle();
        issue_en = 1'b1; issue_rd = 6'd0;
        step();
        idle();
        rd_en = 1'b1; rs1_addr = 6'd0; rs2_addr = 6'd12;
        #1;
        chk_busy("x0_never_busy", 1'b0, 1'b1);
        step();
        chk_data("x0_read", 64'h0, 64'h0);

        idle();
        step();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
